// File: rtl/latency_pipe_mc.sv
// rtl/latency_pipe_mc.sv - multi-channel programmable write/read latency pipe with drained reconfiguration
module latency_pipe_mc #(
    parameter  int NUM_CH     = 2,
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 3,
    parameter  int MAX_LAT    = 8,
    parameter  int WR_LAT_DEF = 4,
    parameter  int RD_LAT_DEF = 2,
    localparam int LW         = $clog2(MAX_LAT + 1),
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_en,
    input  logic [NUM_CH-1:0]            i_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_din,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_rdata,
    input  logic [NUM_CH-1:0]            i_rvld,
    input  logic [NUM_CH-1:0]            i_flush,
    input  logic                         i_cfg_vld,
    input  logic [CW-1:0]                i_cfg_ch,
    input  logic [LW-1:0]                i_cfg_wr_lat,
    input  logic [LW-1:0]                i_cfg_rd_lat,
    output logic                         o_cfg_ack,
    output logic [NUM_CH-1:0]            o_ready,
    output logic [NUM_CH-1:0]            o_busy,
    output logic [NUM_CH-1:0]            o_en,
    output logic [NUM_CH-1:0]            o_we,
    output logic [NUM_CH*ADDR_WIDTH-1:0] o_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_din,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_rdata,
    output logic [NUM_CH-1:0]            o_rvld
);

    localparam int NS = MAX_LAT - 1;

    typedef enum logic [1:0] {CFG_IDLE, CFG_DRAIN, CFG_APPLY} cfg_state_t;

    function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] v);
        if (v == '0) return LW'(1);
        if (int'(v) > MAX_LAT) return LW'(MAX_LAT);
        return v;
    endfunction

    cfg_state_t        cfg_state;
    logic [CW-1:0]     cfg_ch;
    logic [LW-1:0]     cfg_wr_lat;
    logic [LW-1:0]     cfg_rd_lat;
    logic              cfg_ack;
    logic [LW-1:0]     wr_lat [NUM_CH];
    logic [LW-1:0]     rd_lat [NUM_CH];
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] busy;
    logic              sel_busy;
    logic              sel_flush;
    logic              sel_rvld;
    logic              sel_quiet;

    always_comb begin
        sel_busy  = 1'b0;
        sel_flush = 1'b0;
        sel_rvld  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == CW'(c)) begin
                sel_busy  = busy[c];
                sel_flush = i_flush[c];
                sel_rvld  = i_rvld[c];
            end
        end
    end

    // A read beat arriving in the APPLY cycle would straddle the latency change, so apply only when truly quiet
    assign sel_quiet = sel_flush | (~sel_busy & ~sel_rvld);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_state  <= CFG_IDLE;
            cfg_ch     <= '0;
            cfg_wr_lat <= '0;
            cfg_rd_lat <= '0;
            cfg_ack    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_lat[c] <= clamp_lat(LW'(WR_LAT_DEF));
                rd_lat[c] <= clamp_lat(LW'(RD_LAT_DEF));
            end
        end else begin
            cfg_ack <= 1'b0;
            case (cfg_state)
                CFG_IDLE: begin
                    if (i_cfg_vld) begin
                        cfg_ch     <= i_cfg_ch;
                        cfg_wr_lat <= i_cfg_wr_lat;
                        cfg_rd_lat <= i_cfg_rd_lat;
                        cfg_state  <= CFG_DRAIN;
                    end
                end
                CFG_DRAIN: begin
                    if (~sel_busy | sel_flush) cfg_state <= CFG_APPLY;
                end
                CFG_APPLY: begin
                    if (sel_quiet) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (cfg_ch == CW'(c)) begin
                                wr_lat[c] <= clamp_lat(cfg_wr_lat);
                                rd_lat[c] <= clamp_lat(cfg_rd_lat);
                            end
                        end
                        cfg_ack   <= 1'b1;
                        cfg_state <= CFG_IDLE;
                    end else begin
                        cfg_state <= CFG_DRAIN;
                    end
                end
                default: cfg_state <= CFG_IDLE;
            endcase
        end
    end

    assign o_cfg_ack = cfg_ack & ~i_rst;
    assign o_busy    = busy & {NUM_CH{~i_rst}};
    assign o_ready   = ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                  in_w;
        logic                  in_r;
        logic [NS-1:0]         w_vld;
        logic [NS-1:0]         w_we;
        logic [NS-1:0]         r_vld;
        logic [ADDR_WIDTH-1:0] w_addr [NS];
        logic [DATA_WIDTH-1:0] w_din  [NS];
        logic [DATA_WIDTH-1:0] r_dat  [NS];
        logic [NS-1:0]         w_vld_src;
        logic [NS-1:0]         w_we_src;
        logic [NS-1:0]         r_vld_src;
        logic [ADDR_WIDTH-1:0] w_addr_src [NS];
        logic [DATA_WIDTH-1:0] w_din_src  [NS];
        logic [DATA_WIDTH-1:0] r_dat_src  [NS];
        logic                  t_en;
        logic                  t_we;
        logic                  t_rvld;
        logic [ADDR_WIDTH-1:0] t_addr;
        logic [DATA_WIDTH-1:0] t_din;
        logic [DATA_WIDTH-1:0] t_rdat;

        assign ready[c] = ~i_rst & ~((cfg_state != CFG_IDLE) && (cfg_ch == CW'(c)));
        assign in_w     = i_en[c] & ready[c] & ~i_flush[c];
        assign in_r     = i_rvld[c] & ~i_rst & ~i_flush[c];

        // Source of each stage: index 0 is the gated input beat, index j is stage j-1
        always_comb begin
            w_vld_src[0]  = in_w;
            w_we_src[0]   = in_w & i_we[c];
            w_addr_src[0] = in_w ? i_addr[c*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            w_din_src[0]  = in_w ? i_din[c*DATA_WIDTH +: DATA_WIDTH] : '0;
            r_vld_src[0]  = in_r;
            r_dat_src[0]  = in_r ? i_rdata[c*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int j = 1; j < NS; j++) begin
                w_vld_src[j]  = w_vld[j-1];
                w_we_src[j]   = w_we[j-1];
                w_addr_src[j] = w_addr[j-1];
                w_din_src[j]  = w_din[j-1];
                r_vld_src[j]  = r_vld[j-1];
                r_dat_src[j]  = r_dat[j-1];
            end
        end

        // Stages past the selected tap are held empty so a later latency increase never exposes stale beats
        always_ff @(posedge i_clk) begin
            for (int j = 0; j < NS; j++) begin
                if (i_rst || i_flush[c] || (j + 2 > int'(wr_lat[c]))) begin
                    w_vld[j]  <= 1'b0;
                    w_we[j]   <= 1'b0;
                    w_addr[j] <= '0;
                    w_din[j]  <= '0;
                end else begin
                    w_vld[j]  <= w_vld_src[j];
                    w_we[j]   <= w_we_src[j];
                    w_addr[j] <= w_addr_src[j];
                    w_din[j]  <= w_din_src[j];
                end
                if (i_rst || i_flush[c] || (j + 2 > int'(rd_lat[c]))) begin
                    r_vld[j] <= 1'b0;
                    r_dat[j] <= '0;
                end else begin
                    r_vld[j] <= r_vld_src[j];
                    r_dat[j] <= r_dat_src[j];
                end
            end
        end

        always_comb begin
            t_en   = w_vld_src[0];
            t_we   = w_we_src[0];
            t_addr = w_addr_src[0];
            t_din  = w_din_src[0];
            t_rvld = r_vld_src[0];
            t_rdat = r_dat_src[0];
            for (int j = 0; j < NS; j++) begin
                if (int'(wr_lat[c]) == j + 2) begin
                    t_en   = w_vld[j];
                    t_we   = w_we[j];
                    t_addr = w_addr[j];
                    t_din  = w_din[j];
                end
                if (int'(rd_lat[c]) == j + 2) begin
                    t_rvld = r_vld[j];
                    t_rdat = r_dat[j];
                end
            end
        end

        assign busy[c] = (|w_vld) | (|r_vld);

        assign o_en[c]                                 = t_en & ~i_rst;
        assign o_we[c]                                 = t_we & ~i_rst;
        assign o_rvld[c]                               = t_rvld & ~i_rst;
        assign o_addr[c*ADDR_WIDTH +: ADDR_WIDTH]      = i_rst ? '0 : t_addr;
        assign o_din[c*DATA_WIDTH +: DATA_WIDTH]       = i_rst ? '0 : t_din;
        assign o_rdata[c*DATA_WIDTH +: DATA_WIDTH]     = i_rst ? '0 : t_rdat;
    end

endmodule
